// File: rtl/scan_tail_checker.sv
// Scan-chain tail checker: after an arm request, measures how many scan ticks it
// takes for the tail pin to go high and how long it stays high, then gives a verdict.
module scan_tail_checker #(
    parameter int LEN_W        = 16,
    parameter int EXPECTED_LEN = 0,
    parameter int PULSE_CYCLES = 2,
    parameter int TIMEOUT      = 65535
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             logic_clk,
    input  logic             start,
    input  logic             sc_tail,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [LEN_W-1:0] len_out,
    output logic [LEN_W-1:0] width_out
);

    localparam logic [LEN_W-1:0] TO_L    = LEN_W'(TIMEOUT);
    localparam logic [LEN_W-1:0] EXP_L   = LEN_W'(EXPECTED_LEN);
    localparam logic [LEN_W-1:0] PULSE_L = LEN_W'(PULSE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HIGH  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q;
    logic             lclk_q;
    logic [LEN_W-1:0] cnt_q, len_q, wid_q;
    logic             pass_q, to_q;

    logic             tick, tail_s;
    logic [LEN_W-1:0] cnt_d, wid_d;

    // One strobe per scan-clock falling edge; tail is only looked at on it.
    assign tick   = lclk_q & ~logic_clk;
    assign tail_s = sync2_q;
    assign cnt_d  = cnt_q + LEN_W'(1);
    assign wid_d  = wid_q + LEN_W'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lclk_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            wid_q   <= '0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            sync1_q <= sc_tail;
            sync2_q <= sync1_q;
            lclk_q  <= logic_clk;
            case (state_q)
                // A tick coinciding with the arm request is deliberately dropped.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_ARMED;
                        cnt_q   <= '0;
                        len_q   <= '0;
                        wid_q   <= '0;
                        pass_q  <= 1'b0;
                        to_q    <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (tick) begin
                        cnt_q <= cnt_d;
                        if (tail_s) begin
                            state_q <= S_HIGH;
                            len_q   <= cnt_d;
                            wid_q   <= LEN_W'(1);
                        end else if (cnt_d == TO_L) begin
                            state_q <= S_DONE;
                            len_q   <= TO_L;
                            to_q    <= 1'b1;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                S_HIGH: begin
                    if (tick) begin
                        if (tail_s) begin
                            wid_q <= wid_d;
                            if (wid_d == TO_L) begin
                                state_q <= S_DONE;
                                to_q    <= 1'b1;
                                pass_q  <= 1'b0;
                            end
                        end else begin
                            state_q <= S_DONE;
                            pass_q  <= (wid_q == PULSE_L) &&
                                       ((EXPECTED_LEN == 0) || (len_q == EXP_L));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_ARMED) || (state_q == S_HIGH);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign timeout   = to_q;
    assign len_out   = len_q;
    assign width_out = wid_q;

endmodule
